kogge_add_arbiter: RTL
======================

Name: kogge_add_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational N-bit Kogge adder among R requesters.
- Each cycle it grants at most one requester and drives that requester's operands onto the shared adder ports.
- It captures the adder's Sum into a single-entry response register and returns the result tagged with the requester index.
- It keeps a per-requester carry flag so a requester can chain multi-word additions, one N-bit word per request.

Parameters:
N, 4, operand width of the shared adder.
R, 4, number of requesters (minimum 2).
IDW, 2, requester index width; must equal clog2(R).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
Req_Valid  in  R  per-requester request valid.
Req_A  in  R*N  per-requester operand A; requester i uses bits [i*N +: N].
Req_B  in  R*N  per-requester operand B, same packing as Req_A.
Req_Cin  in  R  per-requester explicit carry-in.
Req_Chain  in  R  1 = use the stored carry for this requester instead of Req_Cin.
Req_Ready  out  R  one-hot grant; the request is accepted on a clock edge where Valid and Ready are both 1.
Add_A  out  N  operand A to the shared adder.
Add_B  out  N  operand B to the shared adder.
Add_Cin  out  1  carry-in to the shared adder.
Add_Sum  in  N+1  result from the shared adder (combinational).
Rsp_Valid  out  1  response register full.
Rsp_Sum  out  N+1  captured sum.
Rsp_Id  out  IDW  index of the requester that produced Rsp_Sum.
Rsp_Ready  in  1  consumer accepts the response.
Busy  out  1  Rsp_Valid OR (any Req_Valid).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Rsp_Valid=0, Rsp_Sum=0, Rsp_Id=0.
  - All carry flags Carry_Q[R-1:0]=0.
  - Priority pointer Last=R-1, so requester 0 has top priority after reset.
  - Req_Ready=0 and Add_A/Add_B/Add_Cin=0 while reset is asserted.
  - A response pending at reset is discarded; a half-accepted request is not recorded.
- Response register FSM has two states, EMPTY (Rsp_Valid=0) and FULL (Rsp_Valid=1).
  - Can_Issue = EMPTY OR (FULL AND Rsp_Ready).
- Arbitration (combinational):
  - If Can_Issue, grant g = first i with Req_Valid[i]=1, scanning Last+1, Last+2, … modulo R.
  - Scan order wraps from R-1 to 0.
  - Req_Ready = onehot(g), or all zero if there is no valid requester or Can_Issue=0.
  - Req_Ready may depend combinationally on Req_Valid.
  - Requesters hold Valid and data stable until accepted; Valid is never withdrawn before acceptance.
- Adder drive:
  - While a grant exists: Add_A=Req_A[g], Add_B=Req_B[g], Add_Cin = Req_Chain[g] ? Carry_Q[g] : Req_Cin[g].
  - Otherwise all three are 0.
- On acceptance (edge with a grant):
  - Rsp_Sum<=Add_Sum, Rsp_Id<=g, Rsp_Valid<=1.
  - Carry_Q[g]<=Add_Sum[N], Last<=g.
  - Carry flags of other requesters are unchanged.
- Without acceptance:
  - FULL with Rsp_Ready=1 -> EMPTY (Rsp_Valid<=0).
  - FULL with Rsp_Ready=0 -> hold; Rsp_Sum and Rsp_Id stay stable and no grant is issued.
- Simultaneous drain and accept: the new result loads and Rsp_Valid stays 1, giving throughput of 1 result/cycle.
- Latency: acceptance at edge k -> Rsp_Valid and result visible after edge k.
- Width rules: Sum is N+1 bits and never truncated; Carry_Q stores bit N only.
- Add_Sum is sampled only on acceptance edges; its value in other cycles is ignored.

Test Plan:
- Reset: assert rst_n=0 while FULL with Rsp_Ready=0 -> Rsp_Valid=0, Req_Ready=0, Add_*=0 immediately; after release, only requester 0 valid -> Req_Ready=4'b0001.
- Single request: requester 2 with A=4'h9, B=4'h8, Cin=1, Chain=0 -> Req_Ready=4'b0100 for one cycle; next cycle Rsp_Valid=1, Rsp_Sum=5'h12, Rsp_Id=2.
- Fairness: all four requesters held valid, Rsp_Ready=1 -> one grant per cycle in order 0,1,2,3,0,1 with no gaps; Rsp_Id follows one cycle later.
- Backpressure: Rsp_Ready=0 for 3 cycles while requesters 1 and 3 are valid -> Rsp_Sum and Rsp_Id stable and Req_Ready=0 throughout; on Rsp_Ready=1, same-cycle refill keeps Rsp_Valid=1 and the next grant follows the round-robin order.
- Chaining: requester 1 sends A=4'hF, B=4'h1, Cin=0 -> Rsp_Sum=5'h10, Carry_Q[1]=1; then A=0, B=0, Chain=1 -> Add_Cin=1, Rsp_Sum=5'h01, Carry_Q[1]=0; requester 0 with Chain=1 meanwhile sees Add_Cin=0.
- Exhaustive: connect a real Kogge adder and sweep every {Cin,B,A} on each requester in turn -> every Rsp_Sum equals A+B+Cin (5-bit) with the correct Rsp_Id.

Source files
------------

// File: rtl/kogge_add_arbiter.sv
// kogge_add_arbiter
//   Round-robin arbiter/sequencer sharing one combinational N-bit adder among
//   R requesters. At most one requester is granted per cycle; its operands are
//   driven onto the shared adder and the N+1-bit sum is captured into a
//   single-entry response register tagged with the requester index. A
//   per-requester carry flag lets a requester chain multi-word additions.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   Req_Valid/Ready     per-requester handshake, Ready is a one-hot grant
//   Req_A/Req_B         per-requester operands, requester i at [i*N +: N]
//   Req_Cin/Req_Chain   explicit carry-in, or use stored carry when Chain=1
//   Add_A/Add_B/Add_Cin operands to the shared adder (zero when no grant)
//   Add_Sum             combinational N+1-bit result of the shared adder
//   Rsp_Valid/Ready     response handshake
//   Rsp_Sum/Rsp_Id      captured sum and the index of its requester
//   Busy                response pending or any request valid
module kogge_add_arbiter #(
  parameter int N   = 4,
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   Req_Valid,
  input  logic [R*N-1:0] Req_A,
  input  logic [R*N-1:0] Req_B,
  input  logic [R-1:0]   Req_Cin,
  input  logic [R-1:0]   Req_Chain,
  output logic [R-1:0]   Req_Ready,
  output logic [N-1:0]   Add_A,
  output logic [N-1:0]   Add_B,
  output logic           Add_Cin,
  input  logic [N:0]     Add_Sum,
  output logic           Rsp_Valid,
  output logic [N:0]     Rsp_Sum,
  output logic [IDW-1:0] Rsp_Id,
  input  logic           Rsp_Ready,
  output logic           Busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  rsp_state_e     state_q, state_d;
  logic [IDW-1:0] last_q;
  logic [R-1:0]   carry_q;
  logic [N:0]     sum_q;
  logic [IDW-1:0] id_q;

  logic           can_issue;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] scan_idx;
  logic           issue;

  // A full register may take a new result in the same cycle it drains.
  assign can_issue = (state_q == EMPTY) || Rsp_Ready;

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= R; k++) begin
      scan_idx = IDW'((32'(last_q) + k) % R);
      if (!gnt_found && Req_Valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // rst_n gates the grant so nothing is offered while reset is held.
  assign issue = rst_n && can_issue && gnt_found;

  always_comb begin
    Req_Ready = '0;
    Add_A     = '0;
    Add_B     = '0;
    Add_Cin   = 1'b0;
    for (int unsigned i = 0; i < R; i++) begin
      if (issue && (gnt_idx == IDW'(i))) begin
        Req_Ready[i] = 1'b1;
        Add_A        = Req_A[i*N +: N];
        Add_B        = Req_B[i*N +: N];
        Add_Cin      = Req_Chain[i] ? carry_q[i] : Req_Cin[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (issue) begin
      state_d = FULL;
    end else if ((state_q == FULL) && Rsp_Ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      last_q  <= IDW'(R - 1);
      carry_q <= '0;
      sum_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        sum_q            <= Add_Sum;
        id_q             <= gnt_idx;
        carry_q[gnt_idx] <= Add_Sum[N];
        last_q           <= gnt_idx;
      end
    end
  end

  assign Rsp_Valid = (state_q == FULL);
  assign Rsp_Sum   = sum_q;
  assign Rsp_Id    = id_q;
  assign Busy      = Rsp_Valid || (|Req_Valid);

endmodule
